// File: rtl/avalon_pio_irq_if.sv
// Avalon-MM slave bus bundle for the edge-capturing PIO: zero-wait-state,
// combinational read data.
interface avalon_pio_irq_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/avalon_pio_irq.sv
// Parametrised Avalon-MM GPIO with per-bit direction, atomic set/clear,
// synchronised inputs, edge capture and a level interrupt.
module avalon_pio_irq #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_OUT = '0,
  parameter logic [WIDTH-1:0] RESET_DIR = '0,
  parameter int unsigned      EDGE_TYPE = 0
) (
  input  logic               clk,
  input  logic               reset_n,
  avalon_pio_irq_if.slave    bus,
  input  logic [WIDTH-1:0]   in_port,
  output logic [WIDTH-1:0]   out_port,
  output logic [WIDTH-1:0]   oe,
  output logic               irq
);

  localparam int unsigned BUS_W = 32;

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_DIR     = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET  = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

  logic [WIDTH-1:0] data_out, dir, irqmask, edgecap;
  logic [WIDTH-1:0] data_out_nxt, dir_nxt, irqmask_nxt, edgecap_nxt;
  logic [WIDTH-1:0] s1, s2, prev;
  logic [WIDTH-1:0] edge_det, clear_mask, wdata, rdata;
  logic             wr;
  logic             unused_wdata;

  assign wr           = bus.chipselect & ~bus.write_n;
  assign wdata        = bus.writedata[WIDTH-1:0];
  assign unused_wdata = ^bus.writedata;

  // Edge polarity is fixed at elaboration time.
  if (EDGE_TYPE == 0) begin : g_rise
    assign edge_det = s2 & ~prev;
  end else if (EDGE_TYPE == 1) begin : g_fall
    assign edge_det = ~s2 & prev;
  end else begin : g_any
    assign edge_det = s2 ^ prev;
  end

  // Register-write decode; a simultaneous edge wins over write-1-to-clear.
  always_comb begin
    data_out_nxt = data_out;
    dir_nxt      = dir;
    irqmask_nxt  = irqmask;
    clear_mask   = '0;
    if (wr) begin
      case (bus.address)
        ADDR_DATA:    data_out_nxt = wdata;
        ADDR_DIR:     dir_nxt      = wdata;
        ADDR_IRQMASK: irqmask_nxt  = wdata;
        ADDR_EDGECAP: clear_mask   = wdata;
        ADDR_OUTSET:  data_out_nxt = data_out | wdata;
        ADDR_OUTCLR:  data_out_nxt = data_out & ~wdata;
        default:      ;
      endcase
    end
    edgecap_nxt = (edgecap & ~clear_mask) | edge_det;
  end

  // irq is registered from next-state values so mask/clear writes act after one edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out <= RESET_OUT;
      dir      <= RESET_DIR;
      irqmask  <= '0;
      edgecap  <= '0;
      s1       <= '0;
      s2       <= '0;
      prev     <= '0;
      irq      <= 1'b0;
    end else begin
      data_out <= data_out_nxt;
      dir      <= dir_nxt;
      irqmask  <= irqmask_nxt;
      edgecap  <= edgecap_nxt;
      s1       <= in_port;
      s2       <= s1;
      prev     <= s2;
      irq      <= |(edgecap_nxt & irqmask_nxt);
    end
  end

  // Zero-latency read mux; OUTSET/OUTCLR and unused addresses read as 0.
  always_comb begin
    rdata = '0;
    case (bus.address)
      ADDR_DATA:    rdata = (data_out & dir) | (s2 & ~dir);
      ADDR_DIR:     rdata = dir;
      ADDR_IRQMASK: rdata = irqmask;
      ADDR_EDGECAP: rdata = edgecap;
      default:      rdata = '0;
    endcase
  end

  assign bus.readdata = BUS_W'(rdata);
  assign out_port     = data_out;
  assign oe           = dir;

endmodule

// File: tb/tb_avalon_pio_irq.sv
// Self-checking bench: three PIO variants share one bus stimulus and are
// compared every cycle against a history-based reference model.
module tb_avalon_pio_irq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        cs;
  logic        wn;
  logic [31:0] wd;
  logic [31:0] in_port;

  logic [7:0]  out_a, oe_a;
  logic [31:0] out_b, oe_b;
  logic [3:0]  out_c, oe_c;
  logic        irq_a, irq_b, irq_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  avalon_pio_irq_if bus_a ();
  avalon_pio_irq_if bus_b ();
  avalon_pio_irq_if bus_c ();

  assign bus_a.address = address;  assign bus_a.chipselect = cs;
  assign bus_a.write_n = wn;       assign bus_a.writedata  = wd;
  assign bus_b.address = address;  assign bus_b.chipselect = cs;
  assign bus_b.write_n = wn;       assign bus_b.writedata  = wd;
  assign bus_c.address = address;  assign bus_c.chipselect = cs;
  assign bus_c.write_n = wn;       assign bus_c.writedata  = wd;

  avalon_pio_irq #(.WIDTH(8), .RESET_OUT(8'h00), .RESET_DIR(8'h00), .EDGE_TYPE(0)) u_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a), .in_port(in_port[7:0]),
    .out_port(out_a), .oe(oe_a), .irq(irq_a));

  avalon_pio_irq #(.WIDTH(32), .RESET_OUT(32'hA5A5_0000), .RESET_DIR(32'h0000_FFFF),
                   .EDGE_TYPE(2)) u_b (
    .clk(clk), .reset_n(reset_n), .bus(bus_b), .in_port(in_port),
    .out_port(out_b), .oe(oe_b), .irq(irq_b));

  avalon_pio_irq #(.WIDTH(4), .RESET_OUT(4'h5), .RESET_DIR(4'h3), .EDGE_TYPE(1)) u_c (
    .clk(clk), .reset_n(reset_n), .bus(bus_c), .in_port(in_port[3:0]),
    .out_port(out_c), .oe(oe_c), .irq(irq_c));

  // Reference model: per-variant register values plus a history of sampled inputs.
  logic [31:0] wmask [3] = '{32'h0000_00FF, 32'hFFFF_FFFF, 32'h0000_000F};
  int          etype [3] = '{0, 2, 1};
  logic [31:0] rout  [3] = '{32'h0, 32'hA5A5_0000, 32'h5};
  logic [31:0] rdir  [3] = '{32'h0, 32'h0000_FFFF, 32'h3};
  logic [31:0] m_out [3], m_dir [3], m_msk [3], m_cap [3];
  logic [31:0] smp [3];   // smp[0] newest sample of in_port, taken at clock edges

  function automatic void model_reset();
    for (int d = 0; d < 3; d++) begin
      m_out[d] = rout[d]; m_dir[d] = rdir[d]; m_msk[d] = '0; m_cap[d] = '0;
    end
    for (int i = 0; i < 3; i++) smp[i] = '0;
  endfunction

  function automatic void model_step();
    logic [31:0] now_v, old_v, ed, wv, clr;
    bit w;
    // A change seen in the sample taken two edges ago vs three edges ago is captured now.
    now_v = smp[1];
    old_v = smp[2];
    w = cs && !wn;
    for (int d = 0; d < 3; d++) begin
      wv = wd & wmask[d];
      if (etype[d] == 0)      ed = now_v & ~old_v;
      else if (etype[d] == 1) ed = old_v & ~now_v;
      else                    ed = now_v ^ old_v;
      ed  = ed & wmask[d];
      clr = (w && address == 3'd3) ? wv : 32'h0;
      if (w) begin
        case (address)
          3'd0: m_out[d] = wv;
          3'd1: m_dir[d] = wv;
          3'd2: m_msk[d] = wv;
          3'd4: m_out[d] = m_out[d] | wv;
          3'd5: m_out[d] = m_out[d] & ~wv;
          default: ;
        endcase
      end
      m_cap[d] = (m_cap[d] & ~clr) | ed;
    end
    smp[2] = smp[1];
    smp[1] = smp[0];
    smp[0] = in_port;
  endfunction

  function automatic logic [31:0] exp_rd(int d, logic [2:0] a);
    case (a)
      3'd0:    return (m_out[d] & m_dir[d]) | (smp[1] & ~m_dir[d] & wmask[d]);
      3'd1:    return m_dir[d];
      3'd2:    return m_msk[d];
      3'd3:    return m_cap[d];
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic exp_irq(int d);
    return |(m_cap[d] & m_msk[d]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, " a.out"}, 32'(out_a), m_out[0]);
    chk({tag, " a.oe"},  32'(oe_a),  m_dir[0]);
    chk({tag, " a.irq"}, 32'(irq_a), 32'(exp_irq(0)));
    chk({tag, " b.out"}, out_b,      m_out[1]);
    chk({tag, " b.oe"},  oe_b,       m_dir[1]);
    chk({tag, " b.irq"}, 32'(irq_b), 32'(exp_irq(1)));
    chk({tag, " c.out"}, 32'(out_c), m_out[2]);
    chk({tag, " c.oe"},  32'(oe_c),  m_dir[2]);
    chk({tag, " c.irq"}, 32'(irq_c), 32'(exp_irq(2)));
    if (cs) begin
      chk({tag, " a.rd"}, bus_a.readdata, exp_rd(0, address));
      chk({tag, " b.rd"}, bus_b.readdata, exp_rd(1, address));
      chk({tag, " c.rd"}, bus_c.readdata, exp_rd(2, address));
    end
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address = a; wd = d; cs = 1'b1; wn = 1'b0;
    cycle("wr");
    cs = 1'b0; wn = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a);
    address = a; cs = 1'b1; wn = 1'b1;
    #1;
    check_all("rd");
  endtask

  initial begin
    reset_n = 1'b0; address = '0; cs = 1'b0; wn = 1'b1; wd = '0; in_port = '0;
    model_reset();
    #22;
    chk("reset a.out", 32'(out_a), 32'h0);
    chk("reset a.oe",  32'(oe_a),  32'h0);
    chk("reset a.irq", 32'(irq_a), 32'h0);
    chk("reset b.out", out_b, 32'hA5A5_0000);
    chk("reset c.oe",  32'(oe_c), 32'h3);
    rd(3'd3); chk("reset a.edgecap", bus_a.readdata, 32'h0);
    rd(3'd6); chk("reset a.addr6",   bus_a.readdata, 32'h0);
    cs = 1'b0;
    reset_n = 1'b1;

    // Atomic set/clear on outputs
    wr(3'd1, 32'hFF); wr(3'd0, 32'h3C); wr(3'd4, 32'h81); wr(3'd5, 32'h0C);
    chk("setclr a.out", 32'(out_a), 32'hB1);
    rd(3'd0); chk("setclr a.data", bus_a.readdata, 32'hB1);

    // Rising edge on bit0 reaches irq two edges after the sampling edge
    wr(3'd3, 32'hFFFF_FFFF); wr(3'd2, 32'h01);
    in_port = 32'h1;
    cycle("rise k"); cycle("rise k1");
    chk("rise a.irq k+1", 32'(irq_a), 32'h0);
    cycle("rise k2");
    chk("rise a.irq k+2", 32'(irq_a), 32'h1);
    rd(3'd3); chk("rise a.edgecap", bus_a.readdata, 32'h01);
    cs = 1'b0;
    in_port = 32'h0;
    repeat (3) cycle("fall");
    rd(3'd3); chk("fall a.edgecap", bus_a.readdata, 32'h01);
    cs = 1'b0;
    wr(3'd3, 32'h01);
    chk("clr a.irq", 32'(irq_a), 32'h0);

    // Any-edge capture on bit3 with mask off, then unmask
    wr(3'd3, 32'hFFFF_FFFF); wr(3'd2, 32'h00);
    in_port = 32'h8; repeat (3) cycle("tog up");
    in_port = 32'h0; repeat (3) cycle("tog dn");
    rd(3'd3); chk("any b.edgecap", bus_b.readdata, 32'h08);
    chk("any b.irq masked", 32'(irq_b), 32'h0);
    cs = 1'b0;
    wr(3'd2, 32'h08);
    chk("any b.irq unmask", 32'(irq_b), 32'h1);

    // Clear colliding with a new edge keeps the bit
    wr(3'd3, 32'hFFFF_FFFF); wr(3'd2, 32'h01);
    in_port = 32'h1; repeat (3) cycle("c1 up");
    in_port = 32'h0; repeat (3) cycle("c1 dn");
    in_port = 32'h1; cycle("c2 k"); cycle("c2 k1");
    wr(3'd3, 32'h01);
    chk("collide a.irq", 32'(irq_a), 32'h1);
    rd(3'd3); chk("collide a.edgecap", bus_a.readdata, 32'h01);
    cs = 1'b0;
    wr(3'd3, 32'h01);
    chk("later clr a.irq", 32'(irq_a), 32'h0);

    // Mixed direction read on the 32-bit variant; narrow variant reads zero above WIDTH
    wr(3'd1, 32'hFFFF_0000); wr(3'd0, 32'hFFFF_FFFF);
    in_port = 32'h0000_A5A5;
    repeat (2) cycle("mix");
    rd(3'd0);
    chk("mix b.data", bus_b.readdata, 32'hFFFF_A5A5);
    chk("narrow c.upper", bus_c.readdata & 32'hFFFF_FFF0, 32'h0);
    cs = 1'b0;

    // Random traffic with a reset asserted mid-operation
    for (int i = 0; i < 600; i++) begin
      address = 3'($urandom_range(0, 7));
      cs      = ($urandom_range(0, 3) != 0);
      wn      = 1'($urandom_range(0, 1));
      wd      = $urandom;
      if ($urandom_range(0, 2) == 0) in_port = $urandom;
      if (i == 300) begin
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all("midreset");
        #1;
        reset_n = 1'b1;
      end
      cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/avalon_pio_irq.md
# avalon_pio_irq

Parametrised Avalon-MM general-purpose I/O port with per-bit direction, edge capture and interrupt generation, for the Nios II system alongside the fixed-width output-only PIO. Software drives outputs with atomic set/clear, reads synchronised inputs, and takes a level interrupt on enabled, captured input edges. Zero-wait-state slave: reads are combinational, writes take effect on the next clock edge.

## Interface
- WIDTH, 8: number of I/O bits, 1..32.
- RESET_OUT, 0: reset value of the output data register (WIDTH bits).
- RESET_DIR, 0: reset value of the direction register; bit = 1 means output.
- EDGE_TYPE, 0: 0 = rising, 1 = falling, 2 = any edge captured.

- clk  input  1  system clock.
- reset_n  input  1  reset, asynchronous, active-low.
- address  input  3  register word select.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe, qualified by chipselect.
- writedata  input  32  write data; bits >= WIDTH ignored.
- readdata  output  32  read data; bits >= WIDTH always 0.
- in_port  input  WIDTH  asynchronous pad inputs.
- out_port  output  WIDTH  output data register.
- oe  output  WIDTH  per-bit output enable, equals the direction register.
- irq  output  1  level interrupt, active-high.

## Operation
- Register map, write = chipselect & ~write_n:
  - 0 DATA: read returns, per bit, data_out if dir = 1, else in_sync; a write loads data_out.
  - 1 DIR: read/write direction.
  - 2 IRQMASK: read/write interrupt mask.
  - 3 EDGECAP: read returns the capture register; a write clears every bit written as 1.
  - 4 OUTSET: write ORs writedata into data_out; read returns 0.
  - 5 OUTCLR: write clears the data_out bits written as 1; read returns 0.
  - 6, 7: read 0, writes ignored.
- Input path: two-flop synchroniser (s1, s2) and a previous-value register prev <= s2; in_sync = s2.
- Edge detect per bit:
  - rise = s2 & ~prev
  - fall = ~s2 & prev
  - EDGE_TYPE selects rise, fall or rise|fall.
- Capture: edgecap <= (edgecap & ~clear_mask) | edge. A new edge and a write-1-to-clear of the same bit in the same cycle leave the bit set.
- Capture runs on all bits regardless of direction; software masks off output bits.
- irq = |(edgecap & irqmask), driven from flops only and free of read-path terms.
- Reset values:
  - out_port = RESET_OUT
  - oe = RESET_DIR
  - irqmask, edgecap, s1, s2, prev = 0
  - irq = 0
  - readdata follows the registers.
- Reset assertion mid-operation clears all state immediately. The first sampled input after release cannot create a spurious edge unless in_port differs from 0; a 1 on a rising-edge bit at release therefore captures a legitimate edge two cycles later.

## Timing
- Write on edge k: the register updates at edge k; out_port, oe and irq reflect the new value after k.
- Read: readdata is valid combinationally in the same cycle as address and chipselect (readLatency 0).
- Input latency: in_port changes before edge k.
  - s1 samples at k, s2 at k+1, so DATA shows the new value after k+1.
  - edgecap sets at k+2 and irq rises after k+2.
- Interrupt clear: a write-1-to-clear at edge k drops irq after k, unless a new edge is captured at k.
- Pulses shorter than one clock period may be missed; no capture is guaranteed for them.

## Test plan
- Reset → out_port = RESET_OUT (e.g. 0x00), oe = RESET_DIR, irq = 0, read EDGECAP = 0, read addr 6 = 0.
- Write DIR = 0xFF, DATA = 0x3C, OUTSET = 0x81, OUTCLR = 0x0C → out_port = 0xB1, read DATA = 0xB1.
- EDGE_TYPE = 0, IRQMASK = 0x01, in_port bit0 0→1 at edge k → EDGECAP = 0x01 and irq = 1 after edge k+2; a 1→0 transition captures nothing.
- EDGE_TYPE = 2, IRQMASK = 0x00, toggle bit3 → EDGECAP = 0x08 and irq stays 0; then write IRQMASK = 0x08 → irq = 1 next cycle.
- Write EDGECAP = 0x01 in the same cycle a new bit0 edge is detected → bit0 stays 1 and irq stays 1; a later clear with no edge → irq = 0 the next cycle.
- WIDTH = 32: write DATA = 0xFFFFFFFF with DIR = 0xFFFF0000 and in_port = 0x0000A5A5 → read DATA = 0xFFFFA5A5. WIDTH = 4: read DATA upper 28 bits = 0.
